// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared constants and types for the multiplier result stage.
//               Holds operand/tag widths, result-select op encodings and the
//               result-entry record that travels through the output queue.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

   localparam int XLEN = 64;
   localparam int TAGW = 5;

   // Result-select encodings carried on in_op
   localparam logic [1:0] MUL_LO  = 2'b00;   // low half
   localparam logic [1:0] MUL_HSS = 2'b01;   // high half, signed x signed
   localparam logic [1:0] MUL_HSU = 2'b10;   // high half, signed x unsigned
   localparam logic [1:0] MUL_HUU = 2'b11;   // high half, unsigned x unsigned

   typedef struct packed {
      logic [TAGW-1:0] rd;
      logic [XLEN-1:0] data;
   } res_entry_t;

endpackage
`default_nettype wire

// File: rtl/mul_result_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_result_stage_if
// Description : Handshake bundle around the multiplier result stage.
//               Input side  : in_valid/in_ready, in_op, in_rd, in_a, in_b,
//                             in_prod (2*XLEN unsigned product)
//               Output side : out_valid/out_ready, out_rd, out_data
//               Control     : flush (synchronous discard of all results)
//               slave  - the result stage's view
//               master - the upstream multiplier / writeback view
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_result_stage_if
   import mul_pkg::*;
#(
   parameter int XLEN = mul_pkg::XLEN,
   parameter int TAGW = mul_pkg::TAGW
);

   logic                flush;
   logic                in_valid;
   logic                in_ready;
   logic [1:0]          in_op;
   logic [TAGW-1:0]     in_rd;
   logic [XLEN-1:0]     in_a;
   logic [XLEN-1:0]     in_b;
   logic [2*XLEN-1:0]   in_prod;
   logic                out_valid;
   logic                out_ready;
   logic [TAGW-1:0]     out_rd;
   logic [XLEN-1:0]     out_data;

   modport slave (
      input  flush, in_valid, in_op, in_rd, in_a, in_b, in_prod, out_ready,
      output in_ready, out_valid, out_rd, out_data
   );

   modport master (
      output flush, in_valid, in_op, in_rd, in_a, in_b, in_prod, out_ready,
      input  in_ready, out_valid, out_rd, out_data
   );

endinterface
`default_nettype wire

// File: rtl/mul_result_stage_fifo2_vr.sv
`default_nettype none
// ============================================================================
// Module      : fifo2_vr
// Description : Generic 2-entry valid/ready queue. The head entry drives
//               out_data directly; in_ready is decoded from the occupancy
//               register only, so there is no combinational path from
//               out_ready or in_valid to in_ready.
// Ports       : clk, rst_n (async active-low), flush (sync discard)
//               in_valid/in_ready/in_data   - push side
//               out_valid/out_ready/out_data - pop side (head entry)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo2_vr #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic [1:0]       r_count;
   logic [WIDTH-1:0] r_head;
   logic [WIDTH-1:0] r_tail;
   logic             w_push;
   logic             w_pop;

   assign in_ready  = (r_count < 2'(DEPTH));
   assign out_valid = (r_count != 2'd0);
   assign out_data  = r_head;
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;

   // Entries shift toward the head on pop, so r_head is always the oldest.
   // When the queue drains, r_head keeps its last value (never X after reset).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= 2'd0;
         r_head  <= '0;
         r_tail  <= '0;
      end else if (flush) begin
         r_count <= 2'd0;
      end else begin
         case (r_count)
            2'd0: begin
               if (w_push) begin
                  r_head  <= in_data;
                  r_count <= 2'd1;
               end
            end
            2'd1: begin
               if (w_push && w_pop) begin
                  r_head <= in_data;           // old head leaves, new one takes its place
               end else if (w_push) begin
                  r_tail  <= in_data;
                  r_count <= 2'd2;
               end else if (w_pop) begin
                  r_count <= 2'd0;
               end
            end
            2'd2: begin
               if (w_pop) begin
                  r_head  <= r_tail;
                  r_count <= 2'd1;
               end
            end
            default: r_count <= 2'd0;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/mul_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : mul_result_stage
// Description : Result stage after the 64x64 unsigned multiplier. Applies the
//               signed high-half correction, selects the result half for
//               MUL/MULH/MULHSU/MULHU and queues {rd, data} in a 2-entry
//               valid/ready FIFO feeding register-file writeback.
// Ports       : clk, rst_n (async active-low)
//               bus (slave modport of mul_result_stage_if): flush, input
//               handshake with op/rd/a/b/prod, output handshake with rd/data
// Revision    : 1.0 - initial release
// ============================================================================
module mul_result_stage
   import mul_pkg::*;
#(
   parameter int XLEN  = mul_pkg::XLEN,
   parameter int TAGW  = mul_pkg::TAGW,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   mul_result_stage_if.slave      bus
);

   localparam int C_PW = TAGW + XLEN;

   logic [XLEN-1:0] w_p_hi;
   logic [XLEN-1:0] w_corr_a;
   logic [XLEN-1:0] w_corr_b;
   logic [XLEN-1:0] w_result;
   logic [C_PW-1:0] w_push_entry;
   logic [C_PW-1:0] w_head_entry;

   // Unsigned-to-signed high-half correction: a negative operand interpreted
   // as unsigned carries an extra 2^XLEN, contributing other_operand * 2^XLEN
   // to the product, which is removed from the high half.
   assign w_p_hi   = bus.in_prod[2*XLEN-1:XLEN];
   assign w_corr_a = bus.in_a[XLEN-1] ? bus.in_b : '0;
   assign w_corr_b = bus.in_b[XLEN-1] ? bus.in_a : '0;

   always_comb begin
      w_result = bus.in_prod[XLEN-1:0];
      case (bus.in_op)
         MUL_LO:  w_result = bus.in_prod[XLEN-1:0];
         MUL_HSS: w_result = w_p_hi - w_corr_a - w_corr_b;
         MUL_HSU: w_result = w_p_hi - w_corr_a;
         MUL_HUU: w_result = w_p_hi;
         default: w_result = bus.in_prod[XLEN-1:0];
      endcase
   end

   assign w_push_entry = {bus.in_rd, w_result};

   fifo2_vr #(
      .WIDTH (C_PW),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (bus.flush),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .in_data   (w_push_entry),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .out_data  (w_head_entry)
   );

   assign bus.out_rd   = w_head_entry[C_PW-1:XLEN];
   assign bus.out_data = w_head_entry[XLEN-1:0];

endmodule
`default_nettype wire

// File: tb/tb_mul_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_result_stage
// Description : Directed self-checking bench for mul_result_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_result_stage;
   import mul_pkg::*;

   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;

   mul_result_stage_if bus ();

   mul_result_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [63:0]  ALL1  = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0]  MSB   = 64'h8000_0000_0000_0000;
   localparam logic [127:0] P_A   = 128'h1_FFFF_FFFF_FFFF_FFFE;
   localparam logic [127:0] P_MSB = 128'h4000_0000_0000_0000_0000_0000_0000_0000;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] op, input logic [4:0] rd, input logic [63:0] a,
                        input logic [63:0] b, input logic [127:0] p);
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_rd    = rd;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_prod  = p;
   endtask

   logic [1:0]  ops [4];
   logic [63:0] exps[4];

   initial begin
      n_assert      = 0;
      n_fail        = 0;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_op     = 2'b00;
      bus.in_rd     = '0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_prod   = '0;
      bus.out_ready = 1'b0;
      rst_n         = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      // Reset state, before any clock edge
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_in_ready",  64'(bus.in_ready),  64'd1);
      check("rst_out_rd",    64'(bus.out_rd),    64'd0);
      check("rst_out_data",  bus.out_data,       64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Four ops on a=-1, b=2, back to back with out_ready=1
      ops[0] = MUL_LO;  exps[0] = 64'hFFFF_FFFF_FFFF_FFFE;
      ops[1] = MUL_HUU; exps[1] = 64'h1;
      ops[2] = MUL_HSS; exps[2] = ALL1;
      ops[3] = MUL_HSU; exps[3] = ALL1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(ops[i], 5'(i + 1), ALL1, 64'd2, P_A);
         tick();
         check("t1_valid", 64'(bus.out_valid), 64'd1);
         check("t1_rd",    64'(bus.out_rd),    64'(i + 1));
         check("t1_data",  bus.out_data,       exps[i]);
      end
      bus.in_valid = 1'b0;
      tick();
      check("t1_drain_valid", 64'(bus.out_valid), 64'd0);

      // a=b=2^63: MULH and MULHU both 2^62
      drive(MUL_HSS, 5'd20, MSB, MSB, P_MSB);
      tick();
      check("t2_mulh_rd",   64'(bus.out_rd), 64'd20);
      check("t2_mulh_data", bus.out_data,    64'h4000_0000_0000_0000);
      drive(MUL_HUU, 5'd21, MSB, MSB, P_MSB);
      tick();
      check("t2_mulhu_rd",   64'(bus.out_rd), 64'd21);
      check("t2_mulhu_data", bus.out_data,    64'h4000_0000_0000_0000);
      bus.in_valid = 1'b0;
      tick();

      // Backpressure: fill with rd=3, rd=7; third input ignored
      bus.out_ready = 1'b0;
      drive(MUL_LO, 5'd3, 64'd3, 64'd5, 128'd15);
      tick();
      check("t3_ready_after1", 64'(bus.in_ready), 64'd1);
      drive(MUL_LO, 5'd7, 64'd2, 64'd4, 128'd8);
      tick();
      check("t3_ready_full", 64'(bus.in_ready), 64'd0);
      check("t3_head_rd",    64'(bus.out_rd),   64'd3);
      drive(MUL_LO, 5'd9, 64'd6, 64'd6, 128'd36);
      tick();
      check("t3_hold_rd",    64'(bus.out_rd),    64'd3);
      check("t3_hold_data",  bus.out_data,       64'd15);
      check("t3_hold_valid", 64'(bus.out_valid), 64'd1);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      check("t3_second_rd",   64'(bus.out_rd),    64'd7);
      check("t3_second_data", bus.out_data,       64'd8);
      check("t3_ready_back",  64'(bus.in_ready),  64'd1);
      tick();
      check("t3_empty", 64'(bus.out_valid), 64'd0);

      // Count=1 with simultaneous push and pop
      bus.out_ready = 1'b0;
      drive(MUL_LO, 5'd10, 64'd4, 64'd4, 128'd16);
      tick();
      bus.out_ready = 1'b1;
      drive(MUL_HUU, 5'd11, 64'd0, 64'd0, {64'd77, 64'd0});
      tick();
      check("t4_valid", 64'(bus.out_valid), 64'd1);
      check("t4_rd",    64'(bus.out_rd),    64'd11);
      check("t4_data",  bus.out_data,       64'd77);
      check("t4_ready", 64'(bus.in_ready),  64'd1);
      bus.in_valid = 1'b0;
      tick();
      check("t4_no_dup", 64'(bus.out_valid), 64'd0);

      // Full queue, then flush with in_valid and out_ready asserted
      bus.out_ready = 1'b0;
      drive(MUL_LO, 5'd12, 64'd1, 64'd1, 128'd1);
      tick();
      drive(MUL_LO, 5'd13, 64'd1, 64'd2, 128'd2);
      tick();
      check("t5_full", 64'(bus.in_ready), 64'd0);
      bus.flush     = 1'b1;
      bus.out_ready = 1'b1;
      drive(MUL_LO, 5'd14, 64'd1, 64'd3, 128'd3);
      tick();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      check("t5_flush_valid", 64'(bus.out_valid), 64'd0);
      check("t5_flush_ready", 64'(bus.in_ready),  64'd1);
      tick();
      check("t5_not_captured", 64'(bus.out_valid), 64'd0);

      // Asynchronous reset mid-cycle with two entries queued
      bus.out_ready = 1'b0;
      drive(MUL_LO, 5'd15, 64'd1, 64'd1, 128'd1);
      tick();
      drive(MUL_LO, 5'd16, 64'd1, 64'd1, 128'd1);
      tick();
      bus.in_valid = 1'b0;
      check("t6_pre_full", 64'(bus.in_ready), 64'd0);
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_valid", 64'(bus.out_valid), 64'd0);
      check("t6_async_ready", 64'(bus.in_ready),  64'd1);
      tick();
      rst_n = 1'b1;
      tick();
      bus.out_ready = 1'b1;
      drive(MUL_LO, 5'd2, 64'd3, 64'd5, 128'd15);
      tick();
      bus.in_valid = 1'b0;
      check("t6_fresh_valid", 64'(bus.out_valid), 64'd1);
      check("t6_fresh_rd",    64'(bus.out_rd),    64'd2);
      check("t6_fresh_data",  bus.out_data,       64'd15);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
